// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the execute stage and the aux unit.
// Optional build macro: P32_ALU_ARB_RR_EN selects round-robin arbitration.

`timescale 1ns/1ps

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef WORD
`define WORD [`WORD_SIZE-1:0]
`endif
`ifndef ALU_OPCODE
`define ALU_OPCODE [4:0]
`endif
`ifndef ALU_OP_THA_WORD
`define ALU_OP_THA_WORD 5'h00
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 5'h01
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB 5'h02
`endif
`ifndef ALU_OP_AND
`define ALU_OP_AND 5'h03
`endif
`ifndef ALU_OP_MUL
`define ALU_OP_MUL 5'h05
`endif
`ifndef ALU_OP_CMP
`define ALU_OP_CMP 5'h10
`endif
`ifndef ALU_OP_CGE
`define ALU_OP_CGE 5'h11
`endif
`ifndef ALU_OP_CGT
`define ALU_OP_CGT 5'h12
`endif

module alu_arbiter (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic `ALU_OPCODE com0,
  input  logic `ALU_OPCODE com1,
  input  logic `WORD       a0,
  input  logic `WORD       a1,
  input  logic `WORD       b0,
  input  logic `WORD       b1,
  output logic             ack0,
  output logic             ack1,
  output logic `WORD       res,
  output logic             flg_c,
  output logic             flg_s,
  output logic             flg_z,
  output logic             busy,
  output logic `ALU_OPCODE alu_com,
  output logic `WORD       alu_in0,
  output logic `WORD       alu_in1,
  input  logic `WORD       alu_out,
  input  logic             alu_carry,
  input  logic             alu_sign,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLAG,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_gnt;
  logic `ALU_OPCODE r_com;
  logic `WORD       r_a;
  logic `WORD       r_b;
  logic `WORD       r_res;
  logic             r_flg_c;
  logic             r_flg_s;
  logic             r_flg_z;
  logic             w_any;
  logic             w_take;
  logic             w_gnt;
  logic             w_is_cmp;

  assign w_any  = req0 | req1;
  assign w_take = (r_state == S_IDLE) & w_any;

  assign w_is_cmp = (r_com == `ALU_OP_CMP) |
                    (r_com == `ALU_OP_CGE) |
                    (r_com == `ALU_OP_CGT);

`ifdef P32_ALU_ARB_RR_EN
  logic r_pref;

  // Winner: preferred port on contention, else the lone requester
  always_comb begin
    w_gnt = (req0 & req1) ? r_pref : ~req0;
  end

  // Prefer the port that lost the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pref <= 1'b0;
    end else if (w_take) begin
      r_pref <= ~w_gnt;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it asks
  always_comb begin
    w_gnt = ~req0;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and ALU/handshake outputs; ALU idles on THA_WORD with 0s
  always_comb begin
    w_next  = r_state;
    ack0    = 1'b0;
    ack1    = 1'b0;
    busy    = 1'b1;
    alu_com = `ALU_OP_THA_WORD;
    alu_in0 = '0;
    alu_in1 = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_com = r_com;
        alu_in0 = r_a;
        alu_in1 = r_b;
        w_next  = w_is_cmp ? S_FLAG : S_DONE;
      end
      S_FLAG: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        ack0   = ~r_gnt;
        ack1   = r_gnt;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Latch the winning request so later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt <= 1'b0;
      r_com <= `ALU_OP_THA_WORD;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_take) begin
      r_gnt <= w_gnt;
      r_com <= w_gnt ? com1 : com0;
      r_a   <= w_gnt ? a1 : a0;
      r_b   <= w_gnt ? b1 : b0;
    end
  end

  // Result is captured at the end of the issue cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
    end else if (r_state == S_ISSUE) begin
      r_res <= alu_out;
    end
  end

  // ALU flags are registered, so sample them one cycle after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flg_c <= 1'b0;
      r_flg_s <= 1'b0;
      r_flg_z <= 1'b0;
    end else if (r_state == S_FLAG) begin
      r_flg_c <= alu_carry;
      r_flg_s <= alu_sign;
      r_flg_z <= alu_zero;
    end
  end

  assign res   = r_res;
  assign flg_c = r_flg_c;
  assign flg_s = r_flg_s;
  assign flg_z = r_flg_z;

endmodule
